trivium_decrypt: RTL and testbench
==================================

Name: trivium_decrypt

Overview:
- Receive-side counterpart of the team's Trivium encryptor: streams ciphertext in, XORs it with the Trivium keystream and streams plaintext out.
- Keystream is bit-identical to the encryptor's for the same KEY/IV, so ciphertext from the encryptor decrypts to the original plaintext.
- Unrolls W Trivium rounds per clock.
- Sits between the link receive buffer and the consumer, using valid/ready handshakes on both sides.

Parameters:
- W, 8, bits processed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Must divide 1152.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request: latch key/iv/len and begin
- key  input  80  Trivium key, sampled on start
- iv  input  80  Trivium IV, sampled on start
- len  input  16  number of W-bit ciphertext words, sampled on start
- ct_valid  input  1  ciphertext word available
- ct_data  input  W  ciphertext word
- ct_ready  output  1  decryptor accepts ct_data this cycle
- pt_valid  output  1  plaintext word available
- pt_data  output  W  plaintext word
- pt_ready  input  1  consumer accepts pt_data
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of message

Behaviour:
- Reset (synchronous): state=IDLE; ct_ready=0, pt_valid=0, pt_data=0, busy=0, done=0; word counter=0; state register s[287:0]=0.
- State load on start in IDLE:
  - s[79:0]=key; s[92:80]=0; s[172:93]=iv; s[284:173]=0; s[287:285]=3'b111.
  - Latch len; go to INIT.
  - start is ignored in every non-IDLE state.
- One round, applied W times per advancing cycle, sequentially:
  - t1=s[65]^s[92]; t2=s[161]^s[176]; t3=s[242]^s[287]; z=t1^t2^t3.
  - s[92:0]<={s[91:0], t3^(s[285]&s[286])^s[68]}
  - s[176:93]<={s[175:93], t1^(s[90]&s[91])^s[170]}
  - s[287:177]<={s[286:177], t2^(s[174]&s[175])^s[263]}
- INIT:
  - Advances W rounds every cycle for exactly 1152/W cycles (144 at W=8).
  - No keystream is used.
  - Then go to RUN, or to DONE if len==0.
- RUN:
  - ct_ready = (!pt_valid || pt_ready) && words_remaining!=0. ct_ready is registered-state-derived with no combinational path from ct_valid; it may depend combinationally on pt_ready.
  - On ct_valid&&ct_ready:
    - Advance W rounds.
    - pt_data <= ct_data ^ ks, where ks[i] = z of round i in this group (LSB = earliest round).
    - pt_valid<=1; words_remaining decrements.
  - On pt_valid&&pt_ready with no new accept: pt_valid<=0.
  - Simultaneous output accept and new input accept: pt_valid stays 1 and pt_data is replaced. Full throughput is one word per cycle.
  - State does not advance when the ct handshake does not fire. Stalls on either side never skip or repeat keystream bits.
  - When words_remaining==0 and the last pt word has been accepted, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in that following IDLE cycle.
- Latency: a ct word accepted at edge N is presented as pt_valid/pt_data after edge N (one cycle).
- Timing from start: start sampled at edge N gives INIT during cycles N+1..N+144 (W=8), and ct_ready first high in cycle N+145 (pt side idle).
- Keystream bit k (k from 0) equals bit k of the encryptor's STRM for the same key/iv.
- Reset mid-operation: aborts immediately to reset values. Any in-flight pt word is dropped, and no done pulse is generated.

Test Plan:
- key=0, iv=0, len=4, ct all zeros, pt_ready=1 -> pt words equal keystream words 0..3 from a bit-serial golden model of the recurrence; done pulses once, one cycle after the 4th pt accept.
- key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC, plaintext P (16 random bytes) encrypted by the golden model, fed as ct with len=16 -> pt_data sequence equals P exactly.
- Timing at W=8: start at edge N -> ct_ready low through cycle N+144, first high at N+145; busy high from N+1.
- Backpressure: random ct_valid and pt_ready toggling (~50%) on the plaintext-recovery test -> identical plaintext, no lost or duplicated words, ct_ready never high while pt_valid&&!pt_ready.
- len=0 -> INIT runs 144 cycles, no ct_ready, no pt_valid, single done pulse, then busy=0. A start asserted during INIT is ignored.
- reset asserted mid-RUN (after 2 of 8 words), then a new start with the same key/iv -> outputs at reset values the cycle after reset; the rerun reproduces the word-0 plaintext exactly.

Source files
------------

// File: rtl/trivium_decrypt.sv
// Trivium stream decryptor: W keystream rounds per clock,
// ct in / pt out over valid/ready handshakes.
module trivium_decrypt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [79:0]  key,
    input  logic [79:0]  iv,
    input  logic [15:0]  len,
    input  logic         ct_valid,
    input  logic [W-1:0] ct_data,
    output logic         ct_ready,
    output logic         pt_valid,
    output logic [W-1:0] pt_data,
    input  logic         pt_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam int          CYC  = 1152 / W;
    localparam logic [10:0] LAST = 11'(CYC - 1);

    state_t         r_state;
    state_t         w_next;
    logic [287:0]   r_s;
    logic [287:0]   w_s_adv;
    logic [W-1:0]   w_ks;
    logic [10:0]    r_cnt;
    logic [15:0]    r_rem;
    logic           r_pt_valid;
    logic [W-1:0]   r_pt_data;
    logic           w_ct_ready;
    logic           w_fire;
    logic           w_out_free;

    // W unrolled rounds; ks bit i is the output of round i
    always_comb begin : p_round
        logic t1;
        logic t2;
        logic t3;
        t1      = 1'b0;
        t2      = 1'b0;
        t3      = 1'b0;
        w_s_adv = r_s;
        w_ks    = '0;
        for (int i = 0; i < W; i++) begin
            t1 = w_s_adv[65] ^ w_s_adv[92];
            t2 = w_s_adv[161] ^ w_s_adv[176];
            t3 = w_s_adv[242] ^ w_s_adv[287];
            w_ks[i] = t1 ^ t2 ^ t3;
            w_s_adv = {
                w_s_adv[286:177],
                t2 ^ (w_s_adv[174] & w_s_adv[175]) ^ w_s_adv[263],
                w_s_adv[175:93],
                t1 ^ (w_s_adv[90] & w_s_adv[91]) ^ w_s_adv[170],
                w_s_adv[91:0],
                t3 ^ (w_s_adv[285] & w_s_adv[286]) ^ w_s_adv[68]
            };
        end
    end

    assign w_out_free = !r_pt_valid || pt_ready;

    // next-state and control outputs decoded from the current state
    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        done       = 1'b0;
        w_ct_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                if (r_cnt == LAST) begin
                    w_next = (r_rem == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_ct_ready = w_out_free && (r_rem != 16'd0);
                if (r_rem == 16'd0 && w_out_free) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_fire   = w_ct_ready && ct_valid;
    assign ct_ready = w_ct_ready;
    assign pt_valid = r_pt_valid;
    assign pt_data  = r_pt_data;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // cipher state, counters and plaintext output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s        <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_pt_valid <= 1'b0;
            r_pt_data  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_s   <= {3'b111, 112'd0, iv, 13'd0, key};
                        r_rem <= len;
                        r_cnt <= '0;
                    end
                end
                S_INIT: begin
                    r_s   <= w_s_adv;
                    r_cnt <= r_cnt + 11'd1;
                end
                S_RUN: begin
                    if (w_fire) begin
                        r_s        <= w_s_adv;
                        r_pt_data  <= ct_data ^ w_ks;
                        r_pt_valid <= 1'b1;
                        r_rem      <= r_rem - 16'd1;
                    end else if (r_pt_valid && pt_ready) begin
                        r_pt_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_pt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_decrypt.sv
// Scoreboard bench for trivium_decrypt: a standalone bit-serial
// Trivium model supplies keystream; a monitor pops expected pt words.
module tb_trivium_decrypt;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [79:0]  key = '0;
    logic [79:0]  iv = '0;
    logic [15:0]  len = '0;
    logic         ct_valid = 1'b0;
    logic [W-1:0] ct_data = '0;
    logic         ct_ready;
    logic         pt_valid;
    logic [W-1:0] pt_data;
    logic         pt_ready = 1'b1;
    logic         busy;
    logic         done;

    trivium_decrypt #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .iv       (iv),
        .len      (len),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    bit bp_en = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] ks_w[0:63];

    localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] V1 = 80'hFEDCBA9876543210FEDC;

    logic [7:0] P[0:15] = '{
        8'h3A, 8'hC5, 8'h00, 8'hFF, 8'h7E, 8'h91, 8'h2D, 8'hB4,
        8'h58, 8'hE3, 8'h0F, 8'h66, 8'hA9, 8'h14, 8'hD2, 8'h87
    };

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Standard-form Trivium: A=s1..s93, B=s94..s177, C=s178..s288
    task automatic gen_ks(input logic [79:0] k, input logic [79:0] v,
                          input int nw);
        bit a[1:93];
        bit b[1:84];
        bit c[1:111];
        bit t1, t2, t3, z, na, nb, nc;
        int idx;
        for (int j = 1; j <= 93; j++) a[j] = (j <= 80) ? k[j-1] : 1'b0;
        for (int j = 1; j <= 84; j++) b[j] = (j <= 80) ? v[j-1] : 1'b0;
        for (int j = 1; j <= 111; j++) c[j] = (j >= 109);
        for (int r = 0; r < 1152 + nw * W; r++) begin
            t1 = a[66] ^ a[93];
            t2 = b[69] ^ b[84];
            t3 = c[66] ^ c[111];
            z  = t1 ^ t2 ^ t3;
            na = t3 ^ (c[109] & c[110]) ^ a[69];
            nb = t1 ^ (a[91] & a[92]) ^ b[78];
            nc = t2 ^ (b[82] & b[83]) ^ c[87];
            for (int j = 93; j > 1; j--) a[j] = a[j-1];
            for (int j = 84; j > 1; j--) b[j] = b[j-1];
            for (int j = 111; j > 1; j--) c[j] = c[j-1];
            a[1] = na;
            b[1] = nb;
            c[1] = nc;
            if (r >= 1152) begin
                idx = r - 1152;
                ks_w[idx / W][idx % W] = z;
            end
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        pt_ready = bp_en ? 1'($urandom_range(1)) : 1'b1;
    end

    // monitor: pop expected word on each pt handshake
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset) begin
            if (pt_valid && pt_ready) begin
                acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pt_extra: got %0h expected none", pt_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pt_data", 64'(pt_data), 64'(e));
                end
            end
            if (pt_valid && !pt_ready)
                check("ct_ready_stall", 64'(ct_ready), 64'd0);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_start(input logic [79:0] k, input logic [79:0] v,
                            input logic [15:0] l);
        int hi;
        @(posedge clk);
        #1;
        key = k;
        iv = v;
        len = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi = 0;
        for (int c = 1; c <= 145; c++) begin
            if (l == 16'd0 && c == 60) begin
                start = 1'b1;
                len = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (c == 1) check("busy_after_start", 64'(busy), 64'd1);
            if (c <= 144 && (ct_ready || pt_valid)) hi++;
            if (c == 145) begin
                if (l != 16'd0)
                    check("first_ct_ready", 64'(ct_ready), 64'd1);
                else
                    check("len0_done_time", 64'(done), 64'd1);
            end
        end
        start = 1'b0;
        check("init_quiet", 64'(hi), 64'd0);
    endtask

    task automatic feed(input logic [W-1:0] w);
        int t;
        bit ok;
        if (bp_en) begin
            while ($urandom_range(1) == 0) begin
                ct_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        ct_valid = 1'b1;
        ct_data = w;
        t = 0;
        ok = 1'b0;
        while (!ok && t < 1000) begin
            @(negedge clk);
            if (ct_ready) ok = 1'b1;
            t++;
        end
        if (!ok) check("ct_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        ct_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_msg(input logic [79:0] k, input logic [79:0] v,
                           input int l, input bit pmode);
        int d0;
        int t;
        logic [W-1:0] e;
        gen_ks(k, v, l);
        d0 = n_done;
        do_start(k, v, 16'(l));
        @(posedge clk);
        #1;
        for (int i = 0; i < l; i++) begin
            e = pmode ? P[i] : ks_w[i];
            exp_q.push_back(e);
            feed(pmode ? (P[i] ^ ks_w[i]) : '0);
        end
        t = 0;
        while (n_done == d0 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_seen", 64'(n_done - d0), 64'd1);
        check("done_after_last_pt", 64'(done_cyc), 64'(acc_cyc + 1));
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        #1;
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_single", 64'(n_done - d0), 64'd1);
    endtask

    task automatic run_len0();
        int d0;
        d0 = n_done;
        do_start(K1, V1, 16'd0);
        @(negedge clk);
        #1;
        check("len0_busy_low", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        check("len0_done_single", 64'(n_done - d0), 64'd1);
        check("len0_still_idle", 64'(busy), 64'd0);
    endtask

    task automatic run_reset();
        int d0;
        bp_en = 1'b0;
        gen_ks(K1, V1, 8);
        d0 = n_done;
        do_start(K1, V1, 16'd8);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(P[i]);
            feed(P[i] ^ ks_w[i]);
        end
        wait_drain();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ct_ready", 64'(ct_ready), 64'd0);
        check("rst_pt_valid", 64'(pt_valid), 64'd0);
        check("rst_pt_data", 64'(pt_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_no_done", 64'(n_done - d0), 64'd0);
        run_msg(K1, V1, 2, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ct_ready", 64'(ct_ready), 64'd0);
        check("reset_pt_valid", 64'(pt_valid), 64'd0);
        check("reset_pt_data", 64'(pt_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        bp_en = 1'b0;
        run_msg(80'd0, 80'd0, 4, 1'b0);
        run_msg(K1, V1, 16, 1'b1);
        bp_en = 1'b1;
        run_msg(K1, V1, 16, 1'b1);
        bp_en = 1'b0;
        run_len0();
        run_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
